// File: rtl/smpl_gen_pkg.sv
// rtl/smpl_gen_pkg.sv - shared rasterizer types: sample FSM states and sub-sample decode.
package smpl_gen_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } smpl_state_t;

    // One-hot rate to log2 of samples per pixel edge; 1x1 is also the fallback.
    function automatic logic [1:0] ss_w_lg2_decode(input logic [3:0] sub_sample);
        if (sub_sample[0]) begin
            return 2'd3;
        end else if (sub_sample[1]) begin
            return 2'd2;
        end else if (sub_sample[2]) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

endpackage

// File: rtl/smpl_gen.sv
// rtl/smpl_gen.sv - walks a bounding box on the sub-sample grid, one sample per cycle.
module smpl_gen
    import smpl_gen_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
);

    smpl_state_t state_q, state_d;

    logic signed [SIGFIG-1:0] ll_x_q, ll_y_q, ur_x_q, ur_y_q;
    logic signed [SIGFIG-1:0] samp_x_q, samp_y_q, samp_x_d, samp_y_d;
    logic        [1:0]        ss_w_lg2_q;
    logic                     accept;

    // One extra bit so a step near the signed max cannot wrap past ur.
    logic signed [SIGFIG:0] step, x_sum, y_sum, ur_x_ext, ur_y_ext;
    logic                   x_fits, y_fits, inverted;

    always_comb begin
        state_d  = state_q;
        samp_x_d = samp_x_q;
        samp_y_d = samp_y_q;
        accept   = 1'b0;

        step     = (SIGFIG+1)'(1) << (RADIX - int'(ss_w_lg2_q));
        x_sum    = {samp_x_q[SIGFIG-1], samp_x_q} + step;
        y_sum    = {samp_y_q[SIGFIG-1], samp_y_q} + step;
        ur_x_ext = {ur_x_q[SIGFIG-1], ur_x_q};
        ur_y_ext = {ur_y_q[SIGFIG-1], ur_y_q};
        x_fits   = (x_sum <= ur_x_ext);
        y_fits   = (y_sum <= ur_y_ext);
        inverted = (ll_x_q > ur_x_q) || (ll_y_q > ur_y_q);

        case (state_q)
            WAIT: begin
                if (validTri_R13H) begin
                    accept   = 1'b1;
                    state_d  = TEST;
                    samp_x_d = box_R13S[0][0];
                    samp_y_d = box_R13S[0][1];
                end
            end
            TEST: begin
                // An inverted box still yields its lower-left sample, then stops.
                if (inverted || (!x_fits && !y_fits)) begin
                    state_d = WAIT;
                end else if (x_fits) begin
                    samp_x_d = x_sum[SIGFIG-1:0];
                end else begin
                    samp_x_d = ll_x_q;
                    samp_y_d = y_sum[SIGFIG-1:0];
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT;
            samp_x_q   <= '0;
            samp_y_q   <= '0;
            ll_x_q     <= '0;
            ll_y_q     <= '0;
            ur_x_q     <= '0;
            ur_y_q     <= '0;
            ss_w_lg2_q <= '0;
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < AXIS; a++) begin
                    tri_R14S[v][a] <= '0;
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                color_R14U[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            samp_x_q <= samp_x_d;
            samp_y_q <= samp_y_d;
            if (accept) begin
                ll_x_q     <= box_R13S[0][0];
                ll_y_q     <= box_R13S[0][1];
                ur_x_q     <= box_R13S[1][0];
                ur_y_q     <= box_R13S[1][1];
                ss_w_lg2_q <= ss_w_lg2_decode(subSample_RnnnnU);
                tri_R14S   <= tri_R13S;
                color_R14U <= color_R13U;
            end
        end
    end

    assign validSamp_R14H = (state_q == TEST);
    assign halt_RnnnnL    = (state_q == WAIT);
    assign sample_R14S[0] = samp_x_q;
    assign sample_R14S[1] = samp_y_q;

endmodule

// File: tb/tb_smpl_gen.sv
// tb/tb_smpl_gen.sv - directed vector bench for smpl_gen.
module tb_smpl_gen;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R13U [COLORS];
    logic signed [SIGFIG-1:0] box_R13S [2][2];
    logic                     validTri_R13H = 1'b0;
    logic        [3:0]        subSample_RnnnnU = 4'b1000;
    logic                     halt_RnnnnL;
    logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R14U [COLORS];
    logic signed [SIGFIG-1:0] sample_R14S [2];
    logic                     validSamp_R14H;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         llx;
        int         lly;
        int         urx;
        int         ury;
        logic [3:0] ss;
        int         exp_n;
    } vec_t;

    vec_t vecs [10];

    smpl_gen #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int step_of(input logic [3:0] ss);
        case (ss)
            4'b0001: return 128;
            4'b0010: return 256;
            4'b0100: return 512;
            default: return 1024;
        endcase
    endfunction

    task automatic set_box(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] ss, input int seed);
        box_R13S[0][0] = llx[SIGFIG-1:0];
        box_R13S[0][1] = lly[SIGFIG-1:0];
        box_R13S[1][0] = urx[SIGFIG-1:0];
        box_R13S[1][1] = ury[SIGFIG-1:0];
        subSample_RnnnnU = ss;
        for (int v = 0; v < VERTS; v++) begin
            for (int a = 0; a < AXIS; a++) begin
                tri_R13S[v][a] = SIGFIG'(seed * 100 + v * AXIS + a);
            end
        end
        for (int c = 0; c < COLORS; c++) begin
            color_R13U[c] = SIGFIG'(seed * 10 + c);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at a negedge in WAIT.
    task automatic run_vec(input vec_t v, input int seed, output int n, output int bad);
        int step, hx, hy, x, y;
        step = step_of(v.ss);
        hx = (v.urx < v.llx) ? v.llx : v.urx;
        hy = (v.ury < v.lly) ? v.lly : v.ury;
        n = 0;
        bad = 0;
        set_box(v.llx, v.lly, v.urx, v.ury, v.ss, seed);
        validTri_R13H = 1'b1;
        @(posedge clk);
        @(negedge clk);
        validTri_R13H = 1'b0;
        while (validSamp_R14H === 1'b1 && n < 300) begin
            x = int'(sample_R14S[0]);
            y = int'(sample_R14S[1]);
            if (x < v.llx || x > hx || y < v.lly || y > hy ||
                ((x - v.llx) % step) != 0 || ((y - v.lly) % step) != 0 ||
                halt_RnnnnL !== 1'b0) begin
                bad++;
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic seq_1x1(input bit perturb);
        int ex [6] = '{0, 1024, 2048, 0, 1024, 2048};
        int ey [6] = '{0, 0, 0, 1024, 1024, 1024};
        set_box(0, 0, 2048, 1024, 4'b1000, 3);
        validTri_R13H = 1'b1;
        @(posedge clk);
        @(negedge clk);
        validTri_R13H = 1'b0;
        check("tri latched", int'(tri_R14S[2][1]), 307);
        check("color latched", int'(color_R14U[2]), 32);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("seq x[%0d]", i), int'(sample_R14S[0]), ex[i]);
            check($sformatf("seq y[%0d]", i), int'(sample_R14S[1]), ey[i]);
            check($sformatf("seq valid[%0d]", i), int'(validSamp_R14H), 1);
            check($sformatf("seq halt[%0d]", i), int'(halt_RnnnnL), 0);
            if (perturb && i == 1) begin
                set_box(-4096, -4096, 4096, 4096, 4'b0001, 9);
                validTri_R13H = 1'b1;
            end
            if (perturb && i == 2) begin
                validTri_R13H = 1'b0;
                subSample_RnnnnU = 4'b0010;
            end
            @(negedge clk);
        end
        check("seq end valid", int'(validSamp_R14H), 0);
        check("seq end halt", int'(halt_RnnnnL), 1);
        check("tri held", int'(tri_R14S[2][1]), 307);
    endtask

    initial begin
        int n, bad;
        vecs[0] = '{0, 0, 2048, 1024, 4'b1000, 6};
        vecs[1] = '{0, 0, 128, 128, 4'b0001, 4};
        vecs[2] = '{0, 0, 1000, 600, 4'b0100, 4};
        vecs[3] = '{-300, 100, 300, 700, 4'b0010, 9};
        vecs[4] = '{512, 512, 512, 512, 4'b1000, 1};
        vecs[5] = '{1024, 0, 0, 0, 4'b1000, 1};
        vecs[6] = '{0, 1024, 2048, 0, 4'b1000, 1};
        vecs[7] = '{8388000, 0, 8388607, 0, 4'b1000, 1};
        vecs[8] = '{0, 0, 1023, 127, 4'b0001, 8};
        vecs[9] = '{-1024, -1024, 1024, 1024, 4'b1000, 9};

        set_box(0, 0, 0, 0, 4'b1000, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst valid", int'(validSamp_R14H), 0);
        check("rst halt", int'(halt_RnnnnL), 1);
        check("rst sample x", int'(sample_R14S[0]), 0);
        check("rst sample y", int'(sample_R14S[1]), 0);
        check("rst tri", int'(tri_R14S[1][1]), 0);
        check("rst color", int'(color_R14U[1]), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i + 1, n, bad);
            check($sformatf("vec%0d count", i), n, vecs[i].exp_n);
            check($sformatf("vec%0d grid", i), bad, 0);
            check($sformatf("vec%0d halt idle", i), int'(halt_RnnnnL), 1);
        end

        seq_1x1(1'b0);

        // Back-to-back: second triangle held valid is taken on the single WAIT cycle.
        set_box(0, 0, 128, 128, 4'b0001, 1);
        validTri_R13H = 1'b1;
        @(posedge clk);
        @(negedge clk);
        validTri_R13H = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b x[%0d]", i), int'(sample_R14S[0]), (i % 2) * 128);
            check($sformatf("b2b y[%0d]", i), int'(sample_R14S[1]), (i / 2) * 128);
            if (i == 3) begin
                set_box(512, 256, 512, 256, 4'b1000, 2);
                validTri_R13H = 1'b1;
            end
            @(negedge clk);
        end
        check("b2b wait valid", int'(validSamp_R14H), 0);
        check("b2b wait halt", int'(halt_RnnnnL), 1);
        @(negedge clk);
        validTri_R13H = 1'b0;
        check("b2b second valid", int'(validSamp_R14H), 1);
        check("b2b second x", int'(sample_R14S[0]), 512);
        check("b2b second y", int'(sample_R14S[1]), 256);
        @(negedge clk);
        check("b2b second done", int'(validSamp_R14H), 0);

        // Asynchronous reset on the third sample.
        set_box(0, 0, 2048, 1024, 4'b1000, 4);
        validTri_R13H = 1'b1;
        @(posedge clk);
        @(negedge clk);
        validTri_R13H = 1'b0;
        repeat (2) @(negedge clk);
        check("rst mid x", int'(sample_R14S[0]), 2048);
        check("rst mid valid", int'(validSamp_R14H), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst valid", int'(validSamp_R14H), 0);
        check("async rst halt", int'(halt_RnnnnL), 1);
        check("async rst sample", int'(sample_R14S[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[0], 5, n, bad);
        check("post rst count", n, 6);
        check("post rst grid", bad, 0);

        seq_1x1(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
